// File: rtl/ibex_demo_system_pkg.sv
// ibex_demo_system_pkg: fetch target encoding and default memory windows.
package ibex_demo_system_pkg;
   typedef enum logic [1:0] {FetchRam, FetchDbg, FetchErr} fetch_target_e;
   localparam logic [31:0] RAM_BASE = 32'h0010_0000;
   localparam logic [31:0] RAM_MASK = 32'hFFF0_0000;
   localparam logic [31:0] DBG_BASE = 32'h1A11_0000;
   localparam logic [31:0] DBG_MASK = 32'hFFFF_0000;
endpackage

// File: rtl/instr_fetch_router_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [Width-1:0] cnt_o
);
   logic [Width-1:0] cnt_d, cnt_q;
   always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/instr_fetch_router.sv
// instr_fetch_router: steers Ibex fetches to SRAM port B or the debug window,
// answering unmapped fetches with a bus error one cycle after grant.
module instr_fetch_router
   import ibex_demo_system_pkg::*;
#(
   parameter int          AddrWidth = 32,
   parameter int          DataWidth = 32,
   parameter logic [31:0] RamBase   = RAM_BASE,
   parameter logic [31:0] RamMask   = RAM_MASK,
   parameter logic [31:0] DbgBase   = DBG_BASE,
   parameter logic [31:0] DbgMask   = DBG_MASK,
   parameter int          ErrCntW   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 instr_req_i,
   input  logic [AddrWidth-1:0] instr_addr_i,
   output logic                 instr_gnt_o,
   output logic                 instr_rvalid_o,
   output logic [DataWidth-1:0] instr_rdata_o,
   output logic                 instr_err_o,
   output logic                 ram_req_o,
   output logic [AddrWidth-1:0] ram_addr_o,
   input  logic [DataWidth-1:0] ram_rdata_i,
   input  logic                 dbg_busy_i,
   output logic                 dbg_req_o,
   input  logic [DataWidth-1:0] dbg_rdata_i,
   output logic [ErrCntW-1:0]   err_cnt_o
);
   fetch_target_e tgt, sel_d, sel_q;
   logic          rvalid_d, rvalid_q;
   always_comb begin
      tgt = ((instr_addr_i & AddrWidth'(RamMask)) == AddrWidth'(RamBase)) ? FetchRam :
            ((instr_addr_i & AddrWidth'(DbgMask)) == AddrWidth'(DbgBase)) ? FetchDbg : FetchErr;
      ram_req_o   = instr_req_i && tgt == FetchRam;
      dbg_req_o   = instr_req_i && tgt == FetchDbg && !dbg_busy_i;
      instr_gnt_o = ram_req_o || dbg_req_o || (instr_req_i && tgt == FetchErr);
      rvalid_d    = instr_gnt_o;
      sel_d       = instr_gnt_o ? tgt : sel_q;
   end
   // Reset drops any response still in flight.
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         rvalid_q <= 1'b0;
         sel_q    <= FetchRam;
      end else begin
         rvalid_q <= rvalid_d;
         sel_q    <= sel_d;
      end
   assign ram_addr_o     = instr_addr_i;
   assign instr_rvalid_o = rvalid_q;
   assign instr_err_o    = rvalid_q && sel_q == FetchErr;
   assign instr_rdata_o  = sel_q == FetchRam ? ram_rdata_i :
                           sel_q == FetchDbg ? dbg_rdata_i : '0;
   sat_counter #(.Width(ErrCntW)) u_err_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (instr_gnt_o && tgt == FetchErr),
      .cnt_o (err_cnt_o)
   );
endmodule
